// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
//
// Instruction fetch front end. Issues 8-byte aligned fetch requests to an
// instruction memory, pushes the two 32-bit instructions of each response
// (with their PCs) into a small FIFO, and presents the two oldest entries to
// the decoder. A redirect flushes the FIFO and restarts fetch at a new PC.
// A response that was already in flight when the redirect happened is dropped.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 4)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-low (0 = reset)
//   imem_req     fetch request valid
//   imem_addr    fetch address, always 8-byte aligned
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  fetch response valid
//   imem_rdata   response: [31:0] instr at addr, [63:32] instr at addr+4
//   redirect_en  flush and restart fetch at redirect_pc
//   redirect_pc  restart address (bits [1:0] ignored)
//   deq_ready    downstream consumes all presented instructions this cycle
//   instruction  presented instructions, slot 0 = older
//   instr_valid  slot valid flags (slot 1 never valid without slot 0)
//   instr_pc     PC of each presented slot
// ----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic [31:0] instruction [0:1],
    output logic        instr_valid [0:1],
    output logic [31:0] instr_pc    [0:1]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no request outstanding
        S_WAIT = 2'd1,  // request accepted, response pending
        S_DROP = 2'd2   // pending response belongs to a flushed stream
    } state_t;

    state_t state_reg, state_next;

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W-1:0] tail_plus1;
    logic [CNT_W-1:0] count_reg, count_next;

    // PCs are kept as 8-byte block numbers; the low three bits are implied.
    logic [28:0] fetch_blk_reg, fetch_blk_next;  // next block to request
    logic [28:0] resp_blk_reg, resp_blk_next;    // block of the pending request
    logic        skip_low_reg, skip_low_next;    // first response: drop low half

    logic [1:0]  push_cnt;
    logic [1:0]  pop_cnt;
    logic [1:0]  avail_cnt;
    logic        space_ok;

    logic [31:0] wr0_instr, wr0_pc;
    logic [31:0] wr1_instr, wr1_pc;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    // Only bits [31:3] select the block and bit [2] selects the half; the
    // byte offset within an instruction carries no information here.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // A full response is two entries, so a request is only issued when two
    // free slots exist using the count before this cycle's pop. Pops while
    // the request is outstanding can only add room, so the push never
    // overflows.
    assign space_ok  = (count_reg <= CNT_W'(DEPTH - 2));
    assign imem_addr = {fetch_blk_reg, 3'b000};

    // ------------------------------------------------------------------
    // FSM: next state, request and push control
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        fetch_blk_next = fetch_blk_reg;
        resp_blk_next  = resp_blk_reg;
        skip_low_next  = skip_low_reg;
        imem_req       = 1'b0;
        push_cnt       = 2'd0;

        case (state_reg)
            S_IDLE: begin
                // Stray responses while idle are ignored (e.g. one that was
                // in flight across a reset).
                imem_req = rst && !redirect_en && space_ok;
                if (imem_req && imem_ready) begin
                    state_next     = S_WAIT;
                    resp_blk_next  = fetch_blk_reg;
                    fetch_blk_next = fetch_blk_reg + 29'd1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_next = S_IDLE;
                    if (!redirect_en) begin
                        push_cnt      = skip_low_reg ? 2'd1 : 2'd2;
                        skip_low_next = 1'b0;
                    end
                end else if (redirect_en) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                // The flushed stream's response is consumed and discarded.
                // A redirect here changes nothing about that.
                if (imem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (redirect_en) begin
            fetch_blk_next = redirect_pc[31:3];
            skip_low_next  = redirect_pc[2];
            push_cnt       = 2'd0;
        end
    end

    // Write port 0 takes the low half, unless the stream starts at the upper
    // word of the block, in which case only the high half is written.
    always_comb begin
        wr0_instr = skip_low_reg ? imem_rdata[63:32] : imem_rdata[31:0];
        wr0_pc    = skip_low_reg ? {resp_blk_reg, 3'b100} : {resp_blk_reg, 3'b000};
        wr1_instr = imem_rdata[63:32];
        wr1_pc    = {resp_blk_reg, 3'b100};
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        avail_cnt = (count_reg >= CNT_W'(2)) ? 2'd2 : count_reg[1:0];
        pop_cnt   = (deq_ready && !redirect_en) ? avail_cnt : 2'd0;
    end

    assign tail_plus1 = tail_reg + PTR_W'(1);

    always_comb begin
        head_next  = head_reg + PTR_W'(pop_cnt);
        tail_next  = tail_reg + PTR_W'(push_cnt);
        count_next = count_reg + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        if (redirect_en) begin
            head_next  = tail_reg;
            tail_next  = tail_reg;
            count_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            fetch_blk_reg <= RESET_PC[31:3];
            resp_blk_reg  <= RESET_PC[31:3];
            skip_low_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            fetch_blk_reg <= fetch_blk_next;
            resp_blk_reg  <= resp_blk_next;
            skip_low_reg  <= skip_low_next;
        end
    end

    // Storage has no reset; validity is tracked solely by count_reg.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            instr_mem[tail_reg] <= wr0_instr;
            pc_mem[tail_reg]    <= wr0_pc;
        end
        if (push_cnt == 2'd2) begin
            instr_mem[tail_plus1] <= wr1_instr;
            pc_mem[tail_plus1]    <= wr1_pc;
        end
    end

    // ------------------------------------------------------------------
    // Presentation slots, read combinationally from the FIFO head.
    // Slot validity derives from the count, so slot 1 can only be valid
    // when slot 0 is.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [PTR_W-1:0] rd_ptr;
            assign rd_ptr          = head_reg + PTR_W'(gi);
            assign instruction[gi] = instr_mem[rd_ptr];
            assign instr_pc[gi]    = pc_mem[rd_ptr];
            assign instr_valid[gi] = rst && (count_reg > CNT_W'(gi));
        end
    endgenerate

    // Occupancy can never exceed the FIFO size.
    assert property (@(posedge clk) disable iff (!rst) count_reg <= CNT_W'(DEPTH));

endmodule
